// File: rtl/div_operand_sequencer.sv
// div_operand_sequencer: turns one divide/remainder instruction into a stream of
// tail-trimmed, masked 64-bit operand words for the lane's serial divider.
package div_operand_sequencer_pkg;
   typedef enum logic [1:0] {EW8, EW16, EW32, EW64} vew_e;
   typedef enum logic [1:0] {VDIVU, VDIV, VREMU, VREM} ara_op_e;
endpackage

module div_operand_sequencer
   import div_operand_sequencer_pkg::*;
#(
   parameter int VlWidth   = 16,
   parameter int DataWidth = 64,
   parameter int StrbWidth = DataWidth / 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 cmd_valid_i,
   output logic                 cmd_ready_o,
   input  logic [VlWidth-1:0]   cmd_vl_i,
   input  vew_e                 cmd_vew_i,
   input  ara_op_e              cmd_op_i,
   input  logic                 cmd_vm_i,
   input  logic [DataWidth-1:0] opa_i,
   input  logic                 opa_valid_i,
   output logic                 opa_ready_o,
   input  logic [DataWidth-1:0] opb_i,
   input  logic                 opb_valid_i,
   output logic                 opb_ready_o,
   input  logic [StrbWidth-1:0] mask_i,
   input  logic                 mask_valid_i,
   output logic                 mask_ready_o,
   output logic [DataWidth-1:0] div_operand_a_o,
   output logic [DataWidth-1:0] div_operand_b_o,
   output logic [StrbWidth-1:0] div_be_o,
   output logic [StrbWidth-1:0] div_mask_o,
   output ara_op_e              div_op_o,
   output vew_e                 div_vew_o,
   output logic                 div_valid_o,
   input  logic                 div_ready_i,
   input  logic                 div_result_valid_i,
   input  logic                 div_result_ready_i,
   output logic                 busy_o,
   output logic                 done_o
);
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_e;
   localparam logic [StrbWidth:0] One = 1;

   state_e               state_q, state_d;
   vew_e                 vew_q, vew_d, dvew_q, dvew_d;
   ara_op_e              op_q, op_d, dop_q, dop_d;
   logic                 vm_q, vm_d, dvalid_q, dvalid_d;
   logic [VlWidth-1:0]   elem_rem_q, elem_rem_d, issued_q, issued_d, done_cnt_q, done_cnt_d;
   logic [DataWidth-1:0] opa_q, opa_d, opb_q, opb_d;
   logic [StrbWidth-1:0] be_q, be_d, mask_q, mask_d, be_base;
   logic [VlWidth-1:0]   take;
   logic [3:0]           epw, nbytes;
   logic                 fire, res_hs;

   assign epw     = 4'd8 >> vew_q;
   assign take    = (elem_rem_q < VlWidth'(epw)) ? elem_rem_q : VlWidth'(epw);
   assign nbytes  = 4'(take) << vew_q;
   assign be_base = StrbWidth'((One << nbytes) - One);
   // The output register counts as free when the divider takes its word this cycle.
   assign fire    = (state_q == ISSUE) && opa_valid_i && opb_valid_i && (mask_valid_i || vm_q)
                    && (!dvalid_q || div_ready_i);
   assign res_hs  = (state_q != IDLE) && div_result_valid_i && div_result_ready_i;

   assign cmd_ready_o     = (state_q == IDLE);
   assign opa_ready_o     = fire;
   assign opb_ready_o     = fire;
   assign mask_ready_o    = fire && !vm_q;
   assign busy_o          = (state_q != IDLE);
   assign done_o          = (state_q == FIN);
   assign div_operand_a_o = opa_q;
   assign div_operand_b_o = opb_q;
   assign div_be_o        = be_q;
   assign div_mask_o      = mask_q;
   assign div_op_o        = dop_q;
   assign div_vew_o       = dvew_q;
   assign div_valid_o     = dvalid_q;

   always_comb begin
      state_d    = state_q;
      vew_d      = vew_q;
      op_d       = op_q;
      vm_d       = vm_q;
      elem_rem_d = elem_rem_q;
      issued_d   = issued_q;
      done_cnt_d = done_cnt_q + VlWidth'(res_hs);
      opa_d      = opa_q;
      opb_d      = opb_q;
      be_d       = be_q;
      mask_d     = mask_q;
      dop_d      = dop_q;
      dvew_d     = dvew_q;
      dvalid_d   = dvalid_q && !div_ready_i;
      if (fire) begin
         opa_d      = opa_i;
         opb_d      = opb_i;
         be_d       = vm_q ? be_base : be_base & mask_i;
         mask_d     = vm_q ? '0 : mask_i;
         dop_d      = op_q;
         dvew_d     = vew_q;
         dvalid_d   = 1'b1;
         elem_rem_d = elem_rem_q - take;
         issued_d   = issued_q + 1'b1;
      end
      case (state_q)
         IDLE: if (cmd_valid_i) begin
            vew_d      = cmd_vew_i;
            op_d       = cmd_op_i;
            vm_d       = cmd_vm_i;
            elem_rem_d = cmd_vl_i;
            issued_d   = '0;
            done_cnt_d = '0;
            state_d    = (cmd_vl_i == '0) ? FIN : ISSUE;
         end
         ISSUE: state_d = (fire && elem_rem_d == '0) ? DRAIN : ISSUE;
         DRAIN: state_d = (done_cnt_d == issued_q) ? FIN : DRAIN;
         FIN:   state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         vew_q      <= EW8;
         op_q       <= VDIVU;
         vm_q       <= 1'b0;
         elem_rem_q <= '0;
         issued_q   <= '0;
         done_cnt_q <= '0;
         opa_q      <= '0;
         opb_q      <= '0;
         be_q       <= '0;
         mask_q     <= '0;
         dop_q      <= VDIVU;
         dvew_q     <= EW8;
         dvalid_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         vew_q      <= vew_d;
         op_q       <= op_d;
         vm_q       <= vm_d;
         elem_rem_q <= elem_rem_d;
         issued_q   <= issued_d;
         done_cnt_q <= done_cnt_d;
         opa_q      <= opa_d;
         opb_q      <= opb_d;
         be_q       <= be_d;
         mask_q     <= mask_d;
         dop_q      <= dop_d;
         dvew_q     <= dvew_d;
         dvalid_q   <= dvalid_d;
      end
   end
endmodule

// File: tb/tb_div_operand_sequencer.sv
// tb_div_operand_sequencer: randomized operand/divider traffic checked against a
// word-level model of what each instruction should produce.
module tb_div_operand_sequencer;
   import div_operand_sequencer_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        cmd_valid_i = 1'b0, cmd_ready_o;
   logic [15:0] cmd_vl_i = '0;
   vew_e        cmd_vew_i = EW8;
   ara_op_e     cmd_op_i = VDIVU;
   logic        cmd_vm_i = 1'b1;
   logic [63:0] opa_i = '0, opb_i = '0;
   logic        opa_valid_i = 1'b0, opa_ready_o, opb_valid_i = 1'b0, opb_ready_o;
   logic [7:0]  mask_i = '0;
   logic        mask_valid_i = 1'b0, mask_ready_o;
   logic [63:0] div_operand_a_o, div_operand_b_o;
   logic [7:0]  div_be_o, div_mask_o;
   ara_op_e     div_op_o;
   vew_e        div_vew_o;
   logic        div_valid_o, div_ready_i = 1'b0;
   logic        div_result_valid_i = 1'b0, div_result_ready_i = 1'b0;
   logic        busy_o, done_o;
   int          checks = 0, failures = 0;

   div_operand_sequencer dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_vl_i(cmd_vl_i),
      .cmd_vew_i(cmd_vew_i), .cmd_op_i(cmd_op_i), .cmd_vm_i(cmd_vm_i),
      .opa_i(opa_i), .opa_valid_i(opa_valid_i), .opa_ready_o(opa_ready_o),
      .opb_i(opb_i), .opb_valid_i(opb_valid_i), .opb_ready_o(opb_ready_o),
      .mask_i(mask_i), .mask_valid_i(mask_valid_i), .mask_ready_o(mask_ready_o),
      .div_operand_a_o(div_operand_a_o), .div_operand_b_o(div_operand_b_o),
      .div_be_o(div_be_o), .div_mask_o(div_mask_o), .div_op_o(div_op_o), .div_vew_o(div_vew_o),
      .div_valid_o(div_valid_o), .div_ready_i(div_ready_i),
      .div_result_valid_i(div_result_valid_i), .div_result_ready_i(div_result_ready_i),
      .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic drive_idle;
      cmd_valid_i = 1'b0; opa_valid_i = 1'b0; opb_valid_i = 1'b0; mask_valid_i = 1'b0;
      div_ready_i = 1'b0; div_result_valid_i = 1'b0; div_result_ready_i = 1'b0;
   endtask

   task automatic check_reset_outputs(input string name);
      checks++;
      if ({div_valid_o, busy_o, done_o, opa_ready_o, opb_ready_o, mask_ready_o} !== 6'b0 ||
          div_operand_a_o !== '0 || div_operand_b_o !== '0 || div_be_o !== '0 || div_mask_o !== '0 ||
          div_op_o !== VDIVU || div_vew_o !== EW8) begin
         failures++;
         $display("FAIL %s: valid=%b busy=%b done=%b rdy=%b%b%b a=%h b=%h be=%h mask=%h op=%0d vew=%0d, required all zero",
                  name, div_valid_o, busy_o, done_o, opa_ready_o, opb_ready_o, mask_ready_o,
                  div_operand_a_o, div_operand_b_o, div_be_o, div_mask_o, div_op_o, div_vew_o);
      end
   endtask

   // Runs one instruction with the bench acting as operand queues and divider.
   task automatic run_instr(input int vl, input vew_e vew, input ara_op_e op, input logic vm,
                            input int lat, input int stall, input bit full,
                            input bit fixmask, input logic [7:0] mval);
      int epw, words, apops, bpops, mpops, hs, results, last_res, stall_left, n, bytes, exp_done, r;
      bit fin, pv, pr, efire;
      logic [63:0] cur_a, cur_b, pa, pb;
      logic [7:0]  cur_m, ebe, pbe, pmk;
      logic [63:0] qa[$], qb[$];
      logic [7:0]  qbe[$], qmk[$];
      int due[$];
      epw = 8 >> int'(vew);
      words = (vl + epw - 1) / epw;
      apops = 0; bpops = 0; mpops = 0; hs = 0; results = 0; last_res = 0;
      fin = 0; pv = 0; pr = 0; stall_left = stall;
      pa = '0; pb = '0; pbe = '0; pmk = '0;
      cur_a = {$urandom, $urandom}; cur_b = {$urandom, $urandom};
      cur_m = fixmask ? mval : 8'($urandom);
      @(negedge clk_i);
      cmd_valid_i = 1'b1; cmd_vl_i = 16'(vl); cmd_vew_i = vew; cmd_op_i = op; cmd_vm_i = vm;
      #3;
      checks++;
      if (cmd_ready_o !== 1'b1) begin
         failures++; $display("FAIL cmd_ready_idle: got %b required 1", cmd_ready_o);
      end
      @(negedge clk_i);
      cmd_valid_i = 1'b0; cmd_vl_i = 16'($urandom); cmd_vew_i = vew_e'($urandom_range(3));
      cmd_op_i = ara_op_e'($urandom_range(3)); cmd_vm_i = 1'($urandom);
      for (int cyc = 1; cyc <= 600 && !fin; cyc++) begin
         opa_valid_i  = full || ($urandom_range(3) != 0);
         opb_valid_i  = full || ($urandom_range(3) != 0);
         mask_valid_i = full || ($urandom_range(3) != 0);
         opa_i = cur_a; opb_i = cur_b; mask_i = cur_m;
         if (div_valid_o && stall_left > 0) begin
            div_ready_i = 1'b0; stall_left--;
         end else div_ready_i = full || ($urandom_range(3) != 0);
         if (due.size() > 0 && due[0] <= cyc) begin
            div_result_valid_i = 1'b1; div_result_ready_i = 1'b1;
            void'(due.pop_front()); results++; last_res = cyc;
         end else begin
            r = full ? 0 : $urandom_range(2);
            div_result_valid_i = (r == 1); div_result_ready_i = (r == 2);
         end
         #3;
         efire = apops < words && opa_valid_i && opb_valid_i && (vm || mask_valid_i) &&
                 (!div_valid_o || div_ready_i);
         checks++;
         if (opa_ready_o !== efire || opb_ready_o !== efire || mask_ready_o !== (efire && !vm)) begin
            failures++;
            $display("FAIL pop cyc %0d: ready a/b/m=%b%b%b required %b%b%b", cyc,
                     opa_ready_o, opb_ready_o, mask_ready_o, efire, efire, efire && !vm);
         end
         checks++;
         if (busy_o !== 1'b1 || cmd_ready_o !== 1'b0) begin
            failures++; $display("FAIL busy cyc %0d: busy=%b cmd_ready=%b required 1/0", cyc, busy_o, cmd_ready_o);
         end
         if (pv && !pr) begin
            checks++;
            if (div_valid_o !== 1'b1 || div_operand_a_o !== pa || div_operand_b_o !== pb ||
                div_be_o !== pbe || div_mask_o !== pmk) begin
               failures++;
               $display("FAIL hold cyc %0d: valid=%b a=%h be=%h required 1 a=%h be=%h",
                        cyc, div_valid_o, div_operand_a_o, div_be_o, pa, pbe);
            end
         end
         if (words == 0) begin
            checks++;
            if (div_valid_o !== 1'b0) begin
               failures++; $display("FAIL vl0_valid cyc %0d: div_valid=%b required 0", cyc, div_valid_o);
            end
         end
         if (div_valid_o && div_ready_i) begin
            hs++; checks++;
            if (qa.size() == 0) begin
               failures++; $display("FAIL spurious_word cyc %0d: a=%h required no word", cyc, div_operand_a_o);
            end else begin
               if (div_operand_a_o !== qa[0] || div_operand_b_o !== qb[0] || div_be_o !== qbe[0] ||
                   div_mask_o !== qmk[0] || div_op_o !== op || div_vew_o !== vew) begin
                  failures++;
                  $display("FAIL word cyc %0d: a=%h b=%h be=%h m=%h op=%0d vew=%0d required a=%h b=%h be=%h m=%h op=%0d vew=%0d",
                           cyc, div_operand_a_o, div_operand_b_o, div_be_o, div_mask_o, div_op_o, div_vew_o,
                           qa[0], qb[0], qbe[0], qmk[0], op, vew);
               end
               void'(qa.pop_front()); void'(qb.pop_front()); void'(qbe.pop_front()); void'(qmk.pop_front());
            end
            due.push_back(cyc + lat);
         end
         if (opb_ready_o && opb_valid_i) bpops++;
         if (mask_ready_o && mask_valid_i) mpops++;
         if (opa_ready_o && opa_valid_i) begin
            n = vl - apops * epw;
            if (n > epw) n = epw;
            bytes = n << int'(vew);
            ebe = (bytes >= 8) ? 8'hFF : 8'((1 << bytes) - 1);
            qa.push_back(cur_a); qb.push_back(cur_b);
            qbe.push_back(vm ? ebe : ebe & cur_m);
            qmk.push_back(vm ? 8'h00 : cur_m);
            apops++;
            cur_a = {$urandom, $urandom}; cur_b = {$urandom, $urandom};
            cur_m = fixmask ? mval : 8'($urandom);
         end
         if (done_o) begin
            checks++;
            exp_done = (words == 0) ? 1 : ((results == words) ? last_res + 1 : -1);
            if (cyc != exp_done) begin
               failures++; $display("FAIL done_time: done at cycle %0d required %0d", cyc, exp_done);
            end
            fin = 1;
         end
         pv = div_valid_o; pr = div_ready_i;
         pa = div_operand_a_o; pb = div_operand_b_o; pbe = div_be_o; pmk = div_mask_o;
         if (!fin) @(negedge clk_i);
      end
      checks++;
      if (!fin) begin
         failures++; $display("FAIL timeout: done_o=0 after budget required 1 (vl=%0d)", vl);
      end
      checks++;
      if (apops != words || bpops != words || mpops != (vm ? 0 : words) || hs != words) begin
         failures++;
         $display("FAIL counts: pops a/b/m=%0d/%0d/%0d words=%0d required %0d/%0d/%0d/%0d",
                  apops, bpops, mpops, hs, words, words, vm ? 0 : words, words);
      end
      @(negedge clk_i);
      drive_idle();
      #3;
      checks++;
      if (done_o !== 1'b0 || busy_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
         failures++;
         $display("FAIL after_done: done=%b busy=%b cmd_ready=%b required 0/0/1", done_o, busy_o, cmd_ready_o);
      end
   endtask

   task automatic test_reset;
      drive_idle();
      rst_ni = 1'b0;
      #12;
      check_reset_outputs("reset_state");
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   task automatic test_ew64_unmasked;
      run_instr(3, EW64, VDIV, 1'b1, 4, 0, 1'b1, 1'b0, 8'h00);
   endtask

   task automatic test_ew8_tail;
      run_instr(11, EW8, VDIVU, 1'b1, 2, 0, 1'b1, 1'b0, 8'h00);
   endtask

   task automatic test_mask;
      run_instr(4, EW16, VREM, 1'b0, 3, 0, 1'b1, 1'b1, 8'hC3);
   endtask

   task automatic test_stall;
      run_instr(4, EW32, VREMU, 1'b1, 1, 5, 1'b1, 1'b0, 8'h00);
   endtask

   task automatic test_vl_zero;
      run_instr(0, EW32, VDIV, 1'b1, 1, 0, 1'b1, 1'b0, 8'h00);
   endtask

   task automatic test_idle_results;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         div_result_valid_i = 1'b1; div_result_ready_i = 1'b1;
      end
      @(negedge clk_i);
      drive_idle();
      run_instr(5, EW16, VDIVU, 1'b1, 2, 0, 1'b1, 1'b0, 8'h00);
   endtask

   task automatic test_reset_mid;
      @(negedge clk_i);
      cmd_valid_i = 1'b1; cmd_vl_i = 16'd5; cmd_vew_i = EW64; cmd_op_i = VREM; cmd_vm_i = 1'b1;
      opa_valid_i = 1'b1; opb_valid_i = 1'b1; opa_i = {$urandom, $urandom} | 64'h1;
      opb_i = {$urandom, $urandom}; div_ready_i = 1'b0;
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
      @(negedge clk_i);
      #2;
      checks++;
      if (div_valid_o !== 1'b1 || busy_o !== 1'b1) begin
         failures++; $display("FAIL pre_reset: valid=%b busy=%b required 1/1", div_valid_o, busy_o);
      end
      rst_ni = 1'b0;
      #1;
      check_reset_outputs("reset_mid");
      drive_idle();
      @(negedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
      run_instr(7, EW16, VDIV, 1'b0, 2, 0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_random;
      for (int i = 0; i < 25; i++)
         run_instr($urandom_range(40), vew_e'($urandom_range(3)), ara_op_e'($urandom_range(3)),
                   1'($urandom), $urandom_range(1, 4), $urandom_range(3), 1'b0, 1'b0, 8'h00);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t required finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_ew64_unmasked();
      test_ew8_tail();
      test_mask();
      test_stall();
      test_vl_zero();
      test_idle_results();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
